// File: rtl/bsg_axi_stream_pack_pkg.sv
// Shared definitions for the AXI-stream frame packer and unpacker:
// the default terminator payload and the sticky error-bit layout.
package bsg_axi_stream_pack_pkg;

    localparam logic [31:0] sentinel_default_c = 32'hdeadbeef;

    localparam int err_width_c = 3;
    localparam int e_sentinel  = 0;
    localparam int e_empty     = 1;
    localparam int e_overrun   = 2;

    typedef logic [err_width_c-1:0] err_vec_t;

endpackage

// File: rtl/bsg_axi_stream_unpacker_cnt.sv
// Saturating beat counter with async reset and synchronous clear.
module bsg_axi_stream_unpacker_cnt #(
    parameter int width_p   = 2,
    parameter int max_val_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o,
    output logic               at_max_o
);

    localparam logic [width_p-1:0] max_c = width_p'(max_val_p);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i && (count_q != max_c))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == max_c);

endmodule

// File: rtl/bsg_axi_stream_unpacker_hold.sv
// One-entry hold register. Only the valid bit is reset; the payload is
// don't-care whenever valid is low.
module bsg_axi_stream_unpacker_hold #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               drop_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_q,    v_d;
    logic [width_p-1:0] data_q, data_d;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (load_i) begin
            v_d    = 1'b1;
            data_d = data_i;
        end else if (drop_i) begin
            v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) v_q <= 1'b0;
        else         v_q <= v_d;
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: rtl/bsg_axi_stream_unpacker.sv
// Strips the packer's terminator beat and moves last onto the preceding
// data beat; flags sentinel mismatch, empty frame and overrun as sticky errors.
module bsg_axi_stream_unpacker
    import bsg_axi_stream_pack_pkg::*;
#(
    parameter int                 width_p    = 32,
    parameter int                 max_len_p  = 4,
    parameter logic [width_p-1:0] sentinel_p = width_p'(sentinel_default_c)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic                   last_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic                   last_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   ready_i,
    output logic [err_width_c-1:0] error_o,
    input  logic                   error_clear_i
);

    localparam int cnt_w = $clog2(max_len_p);

    logic               hold_v;
    logic [width_p-1:0] hold_data;
    logic [cnt_w-1:0]   cnt_q;
    logic               cnt_at_max;
    logic               accept, data_acc, term_acc;
    err_vec_t           err_q, err_d, err_set;

    assign ready_o  = ~hold_v | ready_i;
    assign accept   = v_i & ready_o;
    assign data_acc = accept & ~last_i;
    assign term_acc = accept &  last_i;

    // A held beat waits for its successor so it knows whether it ends the packet.
    assign v_o    = hold_v & v_i;
    assign last_o = last_i;
    assign data_o = hold_data;

    bsg_axi_stream_unpacker_hold #(
        .width_p (width_p)
    ) hold (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (data_acc),
        .drop_i  (term_acc),
        .data_i  (data_i),
        .v_o     (hold_v),
        .data_o  (hold_data)
    );

    bsg_axi_stream_unpacker_cnt #(
        .width_p   (cnt_w),
        .max_val_p (max_len_p - 1)
    ) beat_cnt (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (term_acc),
        .up_i     (data_acc),
        .count_o  (cnt_q),
        .at_max_o (cnt_at_max)
    );

    always_comb begin
        err_set             = '0;
        err_set[e_sentinel] = term_acc & (data_i != sentinel_p);
        err_set[e_empty]    = term_acc & ~hold_v;
        err_set[e_overrun]  = data_acc & cnt_at_max;
        // Set has priority over clear so a same-cycle error is never lost.
        err_d = (error_clear_i ? err_vec_t'(0) : err_q) | err_set;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) err_q <= '0;
        else         err_q <= err_d;
    end

    assign error_o = err_q;

endmodule

// File: tb/tb_bsg_axi_stream_unpacker.sv
// Directed bench for bsg_axi_stream_unpacker (width 32, max frame length 4).
module tb_bsg_axi_stream_unpacker;

    localparam logic [31:0] SENT = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i, last_i, ready_i, error_clear_i;
    logic [31:0] data_i;
    logic        ready_o, v_o, last_o;
    logic [31:0] data_o;
    logic [2:0]  error_o;

    int total = 0;
    int bad   = 0;
    int fires = 0;
    int base;

    always #5 clk = ~clk;

    bsg_axi_stream_unpacker #(
        .width_p   (32),
        .max_len_p (4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .last_i        (last_i),
        .data_i        (data_i),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .last_o        (last_o),
        .data_o        (data_o),
        .ready_i       (ready_i),
        .error_o       (error_o),
        .error_clear_i (error_clear_i)
    );

    // Output handshakes, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!reset_i && v_o && ready_i) fires++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic r);
        v_i     = v;
        last_i  = l;
        data_i  = d;
        ready_i = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a beat, check the combinational outputs mid-cycle, then clock it.
    task automatic beat(input string tag, input logic l, input logic [31:0] d,
                        input logic exp_v, input logic [31:0] exp_data);
        drive(1'b1, l, d, 1'b1);
        @(negedge clk);
        $display("beat %s: v_i=1 last_i=%0b data_i=%h -> v_o=%0b last_o=%0b data_o=%h err=%b",
                 tag, l, d, v_o, last_o, data_o, error_o);
        chk({tag, ".v_o"}, 64'(v_o), 64'(exp_v));
        chk({tag, ".rdy"}, 64'(ready_o), 64'd1);
        if (exp_v) begin
            chk({tag, ".data"}, 64'(data_o), 64'(exp_data));
            chk({tag, ".last"}, 64'(last_o), 64'(l));
        end
        tick();
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        error_clear_i = 1'b0;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        #2;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        error_clear_i = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        chk("rst.v_o",   64'(v_o),     64'd0);
        chk("rst.rdy",   64'(ready_o), 64'd1);
        chk("rst.err",   64'(error_o), 64'd0);
        chk("rst.last",  64'(last_o),  64'd1);
        tick();
        reset_i = 1'b0;
        idle();
        tick();

        // 1: A1, A2, terminator
        base = fires;
        beat("t1.a1", 1'b0, 32'h000000a1, 1'b0, 32'h0);
        beat("t1.a2", 1'b0, 32'h000000a2, 1'b1, 32'h000000a1);
        beat("t1.t",  1'b1, SENT,         1'b1, 32'h000000a2);
        idle();
        @(negedge clk);
        chk("t1.vidle", 64'(v_o), 64'd0);
        chk("t1.fires", 64'(fires - base), 64'd2);
        chk("t1.err",   64'(error_o), 64'd0);
        tick();

        // 2: two frames back to back; counter returns to zero after each terminator
        beat("t2.d0", 1'b0, 32'h000000d0, 1'b0, 32'h0);
        beat("t2.d1", 1'b0, 32'h000000d1, 1'b1, 32'h000000d0);
        beat("t2.d2", 1'b0, 32'h000000d2, 1'b1, 32'h000000d1);
        chk("t2.cnt3", 64'(dut.cnt_q), 64'd3);
        beat("t2.t0", 1'b1, SENT,         1'b1, 32'h000000d2);
        chk("t2.cnt0a", 64'(dut.cnt_q), 64'd0);
        beat("t2.d3", 1'b0, 32'h000000d3, 1'b0, 32'h0);
        beat("t2.t1", 1'b1, SENT,         1'b1, 32'h000000d3);
        chk("t2.cnt0b", 64'(dut.cnt_q), 64'd0);
        chk("t2.err",   64'(error_o), 64'd0);

        // 3: backpressure holds A1 stable, B loads on the release cycle
        beat("t3.a1", 1'b0, 32'h000000a1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0000000b, 1'b0);
            @(negedge clk);
            $display("stall %0d: ready_o=%0b v_o=%0b data_o=%h", i, ready_o, v_o, data_o);
            chk("t3.stall.rdy",  64'(ready_o), 64'd0);
            chk("t3.stall.v",    64'(v_o),     64'd1);
            chk("t3.stall.data", 64'(data_o),  64'h000000a1);
            tick();
        end
        beat("t3.b", 1'b0, 32'h0000000b, 1'b1, 32'h000000a1);
        // input valid low with a valid hold: nothing is offered
        idle();
        @(negedge clk);
        chk("t3.vlow.v",   64'(v_o),     64'd0);
        chk("t3.vlow.rdy", 64'(ready_o), 64'd1);
        tick();
        beat("t3.t", 1'b1, SENT, 1'b1, 32'h0000000b);
        chk("t3.err", 64'(error_o), 64'd0);

        // 4: empty frame right after reset, then clear; then set-wins-over-clear
        idle();
        do_reset();
        beat("t4.t", 1'b1, SENT, 1'b0, 32'h0);
        idle();
        chk("t4.err", 64'(error_o), 64'b010);
        error_clear_i = 1'b1;
        tick();
        error_clear_i = 1'b0;
        chk("t4.clr", 64'(error_o), 64'b000);
        drive(1'b1, 1'b1, SENT, 1'b1);
        error_clear_i = 1'b1;
        tick();
        idle();
        chk("t4.setwins", 64'(error_o), 64'b010);
        error_clear_i = 1'b1;
        tick();
        error_clear_i = 1'b0;

        // 5: sentinel mismatch still closes the frame
        beat("t5.a1", 1'b0, 32'h000000a1, 1'b0, 32'h0);
        beat("t5.t",  1'b1, 32'h12345678, 1'b1, 32'h000000a1);
        idle();
        chk("t5.err",  64'(error_o), 64'b001);
        chk("t5.hold", 64'(dut.hold_v), 64'd0);
        error_clear_i = 1'b1;
        tick();
        error_clear_i = 1'b0;

        // 6: overrun on the fourth data beat, then asynchronous reset mid-frame
        beat("t6.e0", 1'b0, 32'h000000e0, 1'b0, 32'h0);
        beat("t6.e1", 1'b0, 32'h000000e1, 1'b1, 32'h000000e0);
        beat("t6.e2", 1'b0, 32'h000000e2, 1'b1, 32'h000000e1);
        chk("t6.err3", 64'(error_o), 64'b000);
        beat("t6.e3", 1'b0, 32'h000000e3, 1'b1, 32'h000000e2);
        chk("t6.err4", 64'(error_o), 64'b100);
        chk("t6.sat",  64'(dut.cnt_q), 64'd3);
        drive(1'b1, 1'b0, 32'h000000e4, 1'b0);
        #2;
        chk("t6.pre.v", 64'(v_o), 64'd1);
        reset_i = 1'b1;
        #1;
        $display("async reset: v_o=%0b ready_o=%0b error_o=%b", v_o, ready_o, error_o);
        chk("t6.arst.v",   64'(v_o),     64'd0);
        chk("t6.arst.rdy", 64'(ready_o), 64'd1);
        chk("t6.arst.err", 64'(error_o), 64'b000);
        tick();
        reset_i = 1'b0;
        beat("t6.t", 1'b1, SENT, 1'b0, 32'h0);
        idle();
        chk("t6.empty", 64'(error_o), 64'b010);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout: simulation did not finish, observed=running expected=done");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
